uart_tx_fifo: RTL

//  Byte FIFO feeding the uart transmitter. Producers (control FSM, LCD echo

---
 rtl/uart_tx_fifo.sv | 79 +++++++
 1 files changed

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: byte FIFO that issues one byte at a time to a uart, paced on tx_busy
module uart_tx_fifo #(
  parameter int DEPTH_LOG2   = 4,
  parameter int BUSY_TIMEOUT = 15
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [7:0]            wr_data,
  input  logic                  wr_en,
  output logic                  full,
  output logic                  empty,
  output logic [DEPTH_LOG2:0]   level,
  output logic                  overflow,
  input  logic                  clr_overflow,
  output logic                  timeout_err,
  output logic [7:0]            tx_data,
  output logic                  tx_wr,
  input  logic                  tx_busy
);
  localparam int DEPTH = 2 ** DEPTH_LOG2;
  localparam int TW = $clog2(BUSY_TIMEOUT + 1);
  typedef enum logic [1:0] {IDLE, WAIT_BUSY, WAIT_DONE} state_t;
  state_t state, state_nx;
  logic [7:0] mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr, rd_ptr;
  logic [TW-1:0] tcnt, tcnt_nx;
  logic push, drop, pop, tout;
  assign full = level == (DEPTH_LOG2 + 1)'(DEPTH);
  assign empty = level == '0;
  assign push = wr_en && !full;
  assign drop = wr_en && full;
  // next state: issue a byte when idle, then wait for the uart to take it and finish
  always_comb begin
    state_nx = state;
    tcnt_nx = tcnt;
    pop = 1'b0;
    tout = 1'b0;
    case (state)
      IDLE: begin
        pop = !empty && !tx_busy;
        state_nx = pop ? WAIT_BUSY : IDLE;
        tcnt_nx = '0;
      end
      WAIT_BUSY: begin
        tcnt_nx = tcnt + 1'b1;
        tout = !tx_busy && tcnt_nx == TW'(BUSY_TIMEOUT);
        state_nx = tx_busy ? WAIT_DONE : tout ? IDLE : WAIT_BUSY;
      end
      WAIT_DONE: state_nx = tx_busy ? WAIT_DONE : IDLE;
      default: state_nx = IDLE;
    endcase
  end
  // state, pointers, level, sticky flags and the registered uart strobe/data
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      tcnt <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      level <= '0;
      overflow <= 1'b0;
      timeout_err <= 1'b0;
      tx_data <= 8'h00;
      tx_wr <= 1'b0;
    end else begin
      state <= state_nx;
      tcnt <= tcnt_nx;
      wr_ptr <= push ? wr_ptr + 1'b1 : wr_ptr;
      rd_ptr <= pop ? rd_ptr + 1'b1 : rd_ptr;
      level <= push && !pop ? level + 1'b1 : pop && !push ? level - 1'b1 : level;
      overflow <= drop || (overflow && !clr_overflow);
      timeout_err <= tout || (timeout_err && !clr_overflow);
      tx_wr <= pop;
      if (pop) tx_data <= mem[rd_ptr];
    end
  end
  // storage is left unreset so it can map onto a RAM
  always_ff @(posedge clk) if (push) mem[wr_ptr] <= wr_data;
endmodule
